fetch_packet_unit: RTL
======================

// Module: fetch_packet_unit
// PURPOSE
//  Front-end producer for the instruction fetch buffer. Sends aligned block requests to the
//  I-cache and packs returned words into compacted packets of up to FETCH_WIDTH instructions.
//  Cuts packets at predicted-taken branches, honours buffer back-pressure and handles redirects.
//  Sits between I-cache/branch predictor and the fetch buffer enqueue port.
// PARAMETERS
//  FETCH_WIDTH  4             words per fetch block = max packet size (power of 2)
//  RESET_PC     32'hBFC0_0000 first fetch address after reset
// PORTS
//  clk                  in   1              clock
//  rst                  in   1              reset
//  redirect_valid       in   1              backend flush/redirect
//  redirect_pc          in   32             new fetch PC
//  icache_req_valid     out  1              block request
//  icache_req_addr      out  32             block-aligned address
//  icache_req_ready     in   1              cache accepts request
//  icache_resp_valid    in   1              block data returned
//  icache_resp_data     in   32*FETCH_WIDTH word i at bits [32i+:32]
//  bp_pc                out  32             current fetch PC, to predictor
//  bp_taken             in   1              predicted taken branch in block at/after bp_pc
//  bp_slot              in   log2(FW)       slot of that branch within block
//  bp_target            in   32             predicted target
//  fetch_stall          in   1              fetch buffer almost full
//  enq_insts            out  32 x FW        packet instructions, compacted to slot 0
//  enq_pcs              out  32 x FW        packet PCs
//  enq_valid            out  FW             slot valid, bits [enq_count-1:0] set
//  enq_count            out  log2(FW)+1     number of valid slots
//  enq_ready            out  1              packet valid this cycle
//  enq_predicted_target out  32             packet prediction target
//  enq_predicted_taken  out  1              packet ends in predicted-taken branch
// BEHAVIOUR
//  Reset: rst synchronous, active-high; clock clk. State REQ, fetch_pc=RESET_PC, all outputs 0
//   (icache_req_valid asserts the cycle after rst deasserts if !fetch_stall).
//  States: REQ -> WAIT -> REQ; WAIT -> DRAIN on redirect; DRAIN -> REQ on response.
//  REQ: icache_req_valid = !fetch_stall && !redirect_valid; addr = fetch_pc with low
//   log2(FW)+2 bits cleared. On valid&&ready -> WAIT; latch fetch_pc and bp_* (one outstanding).
//  WAIT: on icache_resp_valid: offset = pc[2+:log2(FW)]; last = bp_taken&&bp_slot>=offset ?
//   bp_slot : FW-1; packet = words offset..last moved to slots 0..last-offset, pcs base+4*k.
//   Packet registered: enq_ready=1 the following cycle for exactly one cycle.
//   next fetch_pc = taken ? bp_target : base + 4*FW (32-bit wrap). -> REQ.
//  Prediction: bp_taken with bp_slot<offset ignored. enq_predicted_* = latched values when
//   taken, else target 0 / taken 0.
//  No buffer overflow: request only issued while !fetch_stall, one packet in flight;
//   enq_ready never waits on the buffer.
//  Redirect (highest priority, any state): fetch_pc <= redirect_pc; any packet on enq this
//   cycle is forced invalid (enq_ready=0). In REQ: no request that cycle, stay REQ. In WAIT
//   without resp -> DRAIN; in WAIT with resp same cycle -> response dropped, -> REQ.
//   In DRAIN: response dropped, stay DRAIN; repeated redirects update fetch_pc only.
//  DRAIN: no requests; on icache_resp_valid discard data -> REQ.
//  rst mid-operation: to REQ/RESET_PC; cache shares rst, no stale response expected.
//  enq_count = last-offset+1, range 1..FW; enq_valid = (1<<enq_count)-1.
// TESTING
//  rst, no stall -> req addr BFC0_0000; resp words A,B,C,D, no bp -> count 4, pcs ..00..0C, next req ..10.
//  redirect_pc 0x0000_1008 -> req addr 0x1000; resp -> count 2, insts w2,w3, pcs 0x1008,0x100C.
//  bp_taken slot 1 target 0x2000, pc 0x1000 -> count 2, predicted_taken 1, next req 0x2000.
//  fetch_stall held 5 cycles in REQ -> no request; released -> request same cycle.
//  redirect 0x3000 while WAIT, resp 2 cycles later -> no enq_ready, next req 0x3000.
//  redirect same cycle as resp -> response dropped, enq_ready stays 0, next req = redirect block.

Source files
------------

// File: rtl/fetch_packet_unit_if.sv
// Bundle of all signals between the fetch packet unit and its neighbours:
// I-cache request/response, branch predictor lookup, redirect and the
// fetch buffer enqueue port.
interface fetch_packet_unit_if #(
  parameter int unsigned FETCH_WIDTH = 4
) ();
  localparam int unsigned OFF_W = $clog2(FETCH_WIDTH);

  logic                                redirect_valid;
  logic [31:0]                         redirect_pc;
  logic                                icache_req_valid;
  logic [31:0]                         icache_req_addr;
  logic                                icache_req_ready;
  logic                                icache_resp_valid;
  logic [32*FETCH_WIDTH-1:0]           icache_resp_data;
  logic [31:0]                         bp_pc;
  logic                                bp_taken;
  logic [OFF_W-1:0]                    bp_slot;
  logic [31:0]                         bp_target;
  logic                                fetch_stall;
  logic [FETCH_WIDTH-1:0][31:0]        enq_insts;
  logic [FETCH_WIDTH-1:0][31:0]        enq_pcs;
  logic [FETCH_WIDTH-1:0]              enq_valid;
  logic [OFF_W:0]                      enq_count;
  logic                                enq_ready;
  logic [31:0]                         enq_predicted_target;
  logic                                enq_predicted_taken;

  // Fetch unit side
  modport master (
    input  redirect_valid, redirect_pc,
    output icache_req_valid, icache_req_addr,
    input  icache_req_ready, icache_resp_valid, icache_resp_data,
    output bp_pc,
    input  bp_taken, bp_slot, bp_target, fetch_stall,
    output enq_insts, enq_pcs, enq_valid, enq_count, enq_ready,
    output enq_predicted_target, enq_predicted_taken
  );

  // Environment side (cache, predictor, backend, fetch buffer)
  modport slave (
    output redirect_valid, redirect_pc,
    input  icache_req_valid, icache_req_addr,
    output icache_req_ready, icache_resp_valid, icache_resp_data,
    input  bp_pc,
    output bp_taken, bp_slot, bp_target, fetch_stall,
    input  enq_insts, enq_pcs, enq_valid, enq_count, enq_ready,
    input  enq_predicted_target, enq_predicted_taken
  );
endinterface

// File: rtl/fetch_packet_unit.sv
// Fetch packet unit: issues one aligned block request at a time to the
// I-cache, compacts the returned words starting at the fetch PC offset and
// ending at a predicted-taken branch (or block end), and presents the packet
// to the fetch buffer for exactly one cycle. Redirects win over everything.
module fetch_packet_unit #(
  parameter int unsigned FETCH_WIDTH = 4,
  parameter logic [31:0] RESET_PC    = 32'hBFC0_0000
) (
  input logic                 clk,
  input logic                 rst,
  fetch_packet_unit_if.master bus
);
  localparam int unsigned OFF_W   = $clog2(FETCH_WIDTH);
  localparam int unsigned CNT_W   = OFF_W + 1;
  localparam int unsigned ALIGN_W = OFF_W + 2;
  localparam logic [31:0] BLOCK_BYTES = 32'(4 * FETCH_WIDTH);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        enq_ready_q, enq_ready_d;
  logic        req_valid;
  logic        latch_req;
  logic        pkt_load;

  // Snapshot of the outstanding request (word address plus prediction)
  logic [31:2]      req_pc_q;
  logic             bp_taken_q;
  logic [OFF_W-1:0] bp_slot_q;
  logic [31:0]      bp_target_q;

  // Registered packet presented on the enqueue port
  logic [FETCH_WIDTH-1:0][31:0] insts_q, pkt_insts;
  logic [FETCH_WIDTH-1:0][31:0] pcs_q, pkt_pcs;
  logic [FETCH_WIDTH-1:0]       valid_q, pkt_valid;
  logic [CNT_W-1:0]             count_q, pkt_count;
  logic [31:0]                  ptgt_q;
  logic                         ptaken_q;

  logic [FETCH_WIDTH-1:0][31:0] words;
  logic [OFF_W-1:0]             offset;
  logic [OFF_W-1:0]             last;
  logic [OFF_W-1:0]             span;
  logic                         taken_eff;
  logic [31:0]                  block_base;
  logic                         out_vld;

  assign words      = bus.icache_resp_data;
  assign offset     = req_pc_q[2 +: OFF_W];
  // A predicted branch before the entry point is not on this path
  assign taken_eff  = bp_taken_q && (bp_slot_q >= offset);
  assign last       = taken_eff ? bp_slot_q : OFF_W'(FETCH_WIDTH - 1);
  assign span       = last - offset;
  assign block_base = {req_pc_q[31:ALIGN_W], ALIGN_W'(0)};

  // Compact words offset..last into slots 0..span
  always_comb begin
    pkt_insts = '0;
    pkt_pcs   = '0;
    pkt_valid = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (OFF_W'(k) <= span) begin
        pkt_insts[k] = words[offset + OFF_W'(k)];
        pkt_pcs[k]   = {req_pc_q, 2'b00} + 32'(4 * k);
        pkt_valid[k] = 1'b1;
      end
    end
    pkt_count = CNT_W'(span) + CNT_W'(1);
  end

  // Next-state, request and packet-load decisions; redirect overrides fetch_pc
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_valid  = 1'b0;
    latch_req  = 1'b0;
    pkt_load   = 1'b0;
    case (state_q)
      S_REQ: begin
        req_valid = !rst && !bus.fetch_stall && !bus.redirect_valid;
        if (req_valid && bus.icache_req_ready) begin
          state_d   = S_WAIT;
          latch_req = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.icache_resp_valid) begin
          state_d = S_REQ;
          if (!bus.redirect_valid) begin
            pkt_load   = 1'b1;
            fetch_pc_d = taken_eff ? bp_target_q : block_base + BLOCK_BYTES;
          end
        end else if (bus.redirect_valid) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The stale response always retires the outstanding request, even
        // if another redirect lands on the same cycle.
        if (bus.icache_resp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
    if (bus.redirect_valid) fetch_pc_d = bus.redirect_pc;
    enq_ready_d = pkt_load;
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      fetch_pc_q  <= RESET_PC;
      enq_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      enq_ready_q <= enq_ready_d;
    end
  end

  // Capture request address and prediction when the cache accepts
  always_ff @(posedge clk) begin
    if (latch_req) begin
      req_pc_q    <= fetch_pc_q[31:2];
      bp_taken_q  <= bus.bp_taken;
      bp_slot_q   <= bus.bp_slot;
      bp_target_q <= bus.bp_target;
    end
  end

  // Register the compacted packet
  always_ff @(posedge clk) begin
    if (pkt_load) begin
      insts_q  <= pkt_insts;
      pcs_q    <= pkt_pcs;
      valid_q  <= pkt_valid;
      count_q  <= pkt_count;
      ptgt_q   <= taken_eff ? bp_target_q : 32'h0;
      ptaken_q <= taken_eff;
    end
  end

  // Packet is visible only in its one cycle and is killed by a redirect
  assign out_vld = enq_ready_q && !bus.redirect_valid;

  assign bus.icache_req_valid     = req_valid;
  assign bus.icache_req_addr      = req_valid ? {fetch_pc_q[31:ALIGN_W], ALIGN_W'(0)} : 32'h0;
  assign bus.bp_pc                = fetch_pc_q;
  assign bus.enq_ready            = out_vld;
  assign bus.enq_insts            = out_vld ? insts_q : '0;
  assign bus.enq_pcs              = out_vld ? pcs_q : '0;
  assign bus.enq_valid            = out_vld ? valid_q : '0;
  assign bus.enq_count            = out_vld ? count_q : '0;
  assign bus.enq_predicted_target = out_vld ? ptgt_q : 32'h0;
  assign bus.enq_predicted_taken  = out_vld && ptaken_q;
endmodule
